// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one byte-wide DRAM port among NUM_REQ execution units
// (load, store, fetch) with round-robin grant and an optional per-requester lock.
//
// Optional feature: define ARB_HOLD_LIMIT_EN to bound a locked owner to MAX_HOLD
// consecutive completions while another requester is waiting.
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   req_valid/lock/we     per-requester request, keep-grant, write-enable
//   req_addr/req_wdata    flattened per-requester address / write data
//   req_ready             completion strobe, only the owner's bit can be set
//   req_rdata             DRAM read data broadcast to all requesters
//   mem_req/we/addr/wdata DRAM request side, driven from the owner while granted
//   mem_ready/mem_rdata   DRAM completion and read data
//   grant_id, busy        current owner and grant-held flag
module mem_port_arbiter #(
   parameter int unsigned NUM_REQ    = 3,
   parameter int unsigned ADDR_WIDTH = 24,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned MAX_HOLD   = 64,
   localparam int unsigned ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ-1:0]              req_lock,
   input  logic [NUM_REQ-1:0]              req_we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]              req_ready,
   output logic [DATA_WIDTH-1:0]           req_rdata,
   output logic                            mem_req,
   output logic                            mem_we,
   output logic [ADDR_WIDTH-1:0]           mem_addr,
   output logic [DATA_WIDTH-1:0]           mem_wdata,
   input  logic                            mem_ready,
   input  logic [DATA_WIDTH-1:0]           mem_rdata,
   output logic [ID_W-1:0]                 grant_id,
   output logic                            busy
);

   localparam logic [0:0] ST_IDLE    = 1'b0;
   localparam logic [0:0] ST_GRANTED = 1'b1;

   // Elaboration-time sanity check on the configuration.
   if (NUM_REQ < 1 || MAX_HOLD < 1) begin : g_bad_cfg
      $error("mem_port_arbiter: NUM_REQ and MAX_HOLD must be at least 1");
   end

   logic [0:0]            state_q, state_d;
   logic [ID_W-1:0]       grant_q, grant_d;
   logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;

   logic                  granted;
   logic                  own_valid, own_lock, own_we;
   logic [ADDR_WIDTH-1:0] own_addr;
   logic [DATA_WIDTH-1:0] own_wdata;
   logic [NUM_REQ-1:0]    owner_oh;
   logic                  xfer_done;
   logic                  hold_hit;
   logic                  drop_c;
   logic                  pick_found;
   logic [ID_W-1:0]       pick_id;
   logic [ID_W-1:0]       next_ptr;

   assign granted = (state_q == ST_GRANTED);

   // Select the current owner's request signals.
   always_comb begin
      own_valid = 1'b0;
      own_lock  = 1'b0;
      own_we    = 1'b0;
      own_addr  = '0;
      own_wdata = '0;
      owner_oh  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant_q == ID_W'(i)) begin
            own_valid   = req_valid[i];
            own_lock    = req_lock[i];
            own_we      = req_we[i];
            own_addr    = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            own_wdata   = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            owner_oh[i] = 1'b1;
         end
      end
   end

   // DRAM side follows the owner combinationally; everything is quiet outside GRANTED.
   assign mem_req   = granted & own_valid;
   assign mem_we    = granted & own_we;
   assign mem_addr  = granted ? own_addr  : '0;
   assign mem_wdata = granted ? own_wdata : '0;
   assign xfer_done = mem_req & mem_ready;
   assign req_ready = xfer_done ? owner_oh : '0;
   assign req_rdata = mem_rdata;
   assign grant_id  = grant_q;
   assign busy      = granted;

   // Round-robin pick: rotate requests so rr_ptr sits at bit 0, take the first set bit.
   always_comb begin
      logic [2*NUM_REQ-1:0] dbl;
      logic [2*NUM_REQ-1:0] rot;
      int unsigned          sum;
      dbl        = {req_valid, req_valid};
      rot        = dbl >> rr_ptr_q;
      pick_found = 1'b0;
      pick_id    = '0;
      sum        = 0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!pick_found && rot[i]) begin
            pick_found = 1'b1;
            sum        = 32'(rr_ptr_q) + i;
            if (sum >= NUM_REQ) sum = sum - NUM_REQ;
            pick_id    = ID_W'(sum);
         end
      end
   end

   assign next_ptr = (grant_q == ID_W'(NUM_REQ-1)) ? '0 : grant_q + ID_W'(1);

   // Release on unlocked completion, unlocked withdrawal, or hold limit.
   assign drop_c = granted & ((xfer_done & ~own_lock) | (~own_valid & ~own_lock) | hold_hit);

`ifdef ARB_HOLD_LIMIT_EN
   localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic              others_pending;

   assign others_pending = |(req_valid & ~owner_oh);

   // Count locked completions while someone else waits; the MAX_HOLD-th one forces release.
   always_comb begin
      hold_cnt_d = hold_cnt_q;
      hold_hit   = 1'b0;
      if (granted && others_pending && xfer_done && own_lock &&
          hold_cnt_q == HOLD_W'(MAX_HOLD - 1)) begin
         hold_hit = 1'b1;
      end
      if (!granted || !others_pending || drop_c || hold_hit) begin
         hold_cnt_d = '0;
      end else if (xfer_done && own_lock) begin
         hold_cnt_d = hold_cnt_q + HOLD_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) hold_cnt_q <= '0;
      else     hold_cnt_q <= hold_cnt_d;
   end
`else
   assign hold_hit = 1'b0;
`endif

   // Next-state logic.
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_found) begin
               state_d = ST_GRANTED;
               grant_d = pick_id;
            end
         end
         ST_GRANTED: begin
            if (drop_c) begin
               state_d  = ST_IDLE;
               rr_ptr_d = next_ptr;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         grant_q  <= '0;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, round-robin order, locked bursts,
// DRAM wait states, hold limit (build-dependent) and reset mid-transfer.
module tb_mem_port_arbiter;

   logic        clk;
   logic        rst;
   logic [2:0]  req_valid, req_lock, req_we;
   logic [71:0] req_addr;
   logic [23:0] req_wdata;
   logic [2:0]  req_ready;
   logic [7:0]  req_rdata;
   logic        mem_req, mem_we;
   logic [23:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_ready;
   logic [7:0]  mem_rdata;
   logic [1:0]  grant_id;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   mem_port_arbiter #(
      .NUM_REQ(3), .ADDR_WIDTH(24), .DATA_WIDTH(8), .MAX_HOLD(4)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_lock(req_lock), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .req_rdata(req_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .grant_id(grant_id), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic v, input logic l, input logic w,
                          input logic [23:0] a, input logic [7:0] d);
      req_valid[i]          = v;
      req_lock[i]           = l;
      req_we[i]             = w;
      req_addr[i*24 +: 24]  = a;
      req_wdata[i*8 +: 8]   = d;
   endtask

   initial begin
      // 1. reset with all requesters valid
      rst = 1'b1;
      req_valid = '0; req_lock = '0; req_we = '0; req_addr = '0; req_wdata = '0;
      mem_ready = 1'b0; mem_rdata = 8'h00;
      set_req(0, 1'b1, 1'b0, 1'b1, 24'h000010, 8'h11);
      set_req(1, 1'b1, 1'b0, 1'b1, 24'h000020, 8'h22);
      set_req(2, 1'b1, 1'b0, 1'b1, 24'h000030, 8'h33);
      #1;
      check("rst_mem_req",   32'(mem_req),   0);
      check("rst_busy",      32'(busy),      0);
      check("rst_req_ready", 32'(req_ready), 0);
      check("rst_grant",     32'(grant_id),  0);
      check("rst_mem_addr",  32'(mem_addr),  0);
      check("rst_mem_wdata", 32'(mem_wdata), 0);
      check("rst_mem_we",    32'(mem_we),    0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_hold_busy",    32'(busy),    0);
      check("rst_hold_mem_req", 32'(mem_req), 0);
      rst = 1'b0;
      #1;
      check("post_rst_idle_req", 32'(mem_req), 0);
      tick();
      check("first_grant_busy", 32'(busy),      1);
      check("first_grant_id",   32'(grant_id),  0);
      check("first_mem_req",    32'(mem_req),   1);
      check("first_mem_addr",   32'(mem_addr),  32'h10);
      check("first_no_ready",   32'(req_ready), 0);

      // 2. three single unlocked writes, round-robin 0,1,2 with idle gaps
      mem_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("rr_grant",     32'(grant_id),  32'(k));
         check("rr_mem_req",   32'(mem_req),   1);
         check("rr_mem_we",    32'(mem_we),    1);
         check("rr_mem_addr",  32'(mem_addr),  32'(16 * (k + 1)));
         check("rr_mem_wdata", 32'(mem_wdata), 32'(17 * (k + 1)));
         check("rr_req_ready", 32'(req_ready), 32'(1 << k));
         tick();
         req_valid[k] = 1'b0;
         #1;
         check("rr_gap_busy",    32'(busy),    0);
         check("rr_gap_mem_req", 32'(mem_req), 0);
         tick();
      end
      check("rr_all_done_idle", 32'(busy), 0);

      // 3. req1 locked 32-write burst while req0 waits
      set_req(1, 1'b1, 1'b1, 1'b1, 24'h000100, 8'h00);
      tick();
      set_req(0, 1'b1, 1'b0, 1'b1, 24'h000040, 8'h44);
      for (int n = 0; n < 32; n++) begin
         set_req(1, 1'b1, (n < 31), 1'b1, 24'(24'h000100 + n), 8'(n));
         #1;
         check("burst_grant", 32'(grant_id),  1);
         check("burst_addr",  32'(mem_addr),  32'(32'h100 + n));
         check("burst_ready", 32'(req_ready), 32'h2);
         tick();
      end
      req_valid[1] = 1'b0;
      #1;
      check("burst_end_idle", 32'(busy), 0);
      tick();
      check("after_burst_grant", 32'(grant_id),  0);
      check("after_burst_busy",  32'(busy),      1);
      check("after_burst_addr",  32'(mem_addr),  32'h40);
      check("after_burst_wdata", 32'(mem_wdata), 32'h44);
      check("after_burst_ready", 32'(req_ready), 32'h1);
      tick();
      req_valid[0] = 1'b0;
      #1;
      check("after_burst_idle", 32'(busy), 0);

      // 4. read with 5 wait states
      mem_ready = 1'b0;
      mem_rdata = 8'hA5;
      set_req(2, 1'b1, 1'b0, 1'b0, 24'h000055, 8'h00);
      tick();
      for (int c = 0; c < 5; c++) begin
         check("wait_grant",   32'(grant_id),  2);
         check("wait_mem_req", 32'(mem_req),   1);
         check("wait_mem_we",  32'(mem_we),    0);
         check("wait_ready",   32'(req_ready), 0);
         tick();
      end
      mem_ready = 1'b1;
      #1;
      check("read_ready", 32'(req_ready), 32'h4);
      check("read_rdata", 32'(req_rdata), 32'hA5);
      check("read_addr",  32'(mem_addr),  32'h55);
      tick();
      req_valid[2] = 1'b0;
      #1;
      check("read_release", 32'(busy), 0);

      // 5. req2 locked, req0 pending: hold limit of 4 (build-dependent)
      set_req(2, 1'b1, 1'b1, 1'b1, 24'h000200, 8'h5A);
      tick();
      check("hold_grant2", 32'(grant_id), 2);
      set_req(0, 1'b1, 1'b0, 1'b1, 24'h000040, 8'h44);
      for (int n = 0; n < 4; n++) begin
         req_addr[2*24 +: 24] = 24'(24'h000200 + n);
         #1;
         check("hold_grant", 32'(grant_id),  2);
         check("hold_ready", 32'(req_ready), 32'h4);
         check("hold_addr",  32'(mem_addr),  32'(32'h200 + n));
         tick();
      end
`ifdef ARB_HOLD_LIMIT_EN
      req_valid[2] = 1'b0;
      req_lock[2]  = 1'b0;
      #1;
      check("hold_forced_release", 32'(busy),    0);
      check("hold_forced_mem_req", 32'(mem_req), 0);
      tick();
`else
      #1;
      check("lock_kept_busy",  32'(busy),      1);
      check("lock_kept_grant", 32'(grant_id),  2);
      check("lock_kept_ready", 32'(req_ready), 32'h4);
      req_valid[2] = 1'b0;
      #1;
      check("lock_idle_mem_req", 32'(mem_req), 0);
      tick();
      check("lock_idle_busy",  32'(busy),      1);
      check("lock_idle_grant", 32'(grant_id),  2);
      check("lock_idle_ready", 32'(req_ready), 0);
      req_lock[2] = 1'b0;
      tick();
      check("unlock_release", 32'(busy), 0);
      tick();
`endif
      check("post_hold_grant", 32'(grant_id), 0);
      check("post_hold_busy",  32'(busy),     1);
      check("post_hold_addr",  32'(mem_addr), 32'h40);
      tick();
      req_valid[0] = 1'b0;

      // 6. reset while a transfer is outstanding
      mem_ready = 1'b0;
      set_req(1, 1'b1, 1'b0, 1'b1, 24'h000300, 8'h77);
      tick();
      check("pre_abort_grant",   32'(grant_id), 1);
      check("pre_abort_mem_req", 32'(mem_req),  1);
      #2;
      rst = 1'b1;
      #1;
      check("abort_mem_req", 32'(mem_req),   0);
      check("abort_busy",    32'(busy),      0);
      check("abort_grant",   32'(grant_id),  0);
      check("abort_ready",   32'(req_ready), 0);
      check("abort_addr",    32'(mem_addr),  0);
      set_req(0, 1'b1, 1'b0, 1'b1, 24'h000040, 8'h44);
      tick();
      rst = 1'b0;
      tick();
      check("reabort_grant", 32'(grant_id), 0);
      check("reabort_busy",  32'(busy),     1);
      check("reabort_addr",  32'(mem_addr), 32'h40);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
